// File: rtl/bmc_pkg.sv
// rtl/bmc_pkg.sv - shared BMC encoder/decoder types and constants
package bmc_pkg;

  localparam int TIMESTAMP_W    = 24;
  localparam int HALF_BIT_TICKS = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LEAD  = 3'd1,
    SYNC  = 3'd2,
    BIT_A = 3'd3,
    BIT_B = 3'd4,
    TAIL  = 3'd5
  } bmc_state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/bmc_encoder_if.sv
// rtl/bmc_encoder_if.sv - payload request/ready handshake into the BMC encoder
interface bmc_encoder_if #(
  parameter int W = 17
);

  logic [W-1:0] data_in;
  logic         data_valid;
  logic         data_ready;

  modport master (output data_in, output data_valid, input data_ready);
  modport slave  (input data_in, input data_valid, output data_ready);

endinterface

// File: rtl/bmc_tick_counter.sv
// rtl/bmc_tick_counter.sv - loadable down-counter with terminal-count flag for lead, half-bit and tail timing
module bmc_tick_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         tc
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign tc = (count == '0);

endmodule

// File: rtl/bmc_encoder.sv
// rtl/bmc_encoder.sv - biphase-mark frame transmitter with active-low envelope
// Optional: BMC_ENCODER_PARITY_EN appends an even-parity bit after the payload.
module bmc_encoder
  import bmc_pkg::*;
#(
  parameter int bit_considered = 17,
  parameter int half_bit_ticks = HALF_BIT_TICKS,
  parameter int lead_ticks     = 4
) (
  input  logic                   clk_96MHz,
  input  logic                   reset_n,
  input  logic                   enabled,
  bmc_encoder_if.slave           tx,
  input  logic [TIMESTAMP_W-1:0] system_timestamp,
  output logic                   d_out,
  output logic                   e_out,
  output logic                   busy,
  output logic [TIMESTAMP_W-1:0] timestamp_frame_start
);

  localparam logic [2:0] S_IDLE  = IDLE;
  localparam logic [2:0] S_LEAD  = LEAD;
  localparam logic [2:0] S_SYNC  = SYNC;
  localparam logic [2:0] S_BIT_A = BIT_A;
  localparam logic [2:0] S_BIT_B = BIT_B;
  localparam logic [2:0] S_TAIL  = TAIL;

  localparam int CNT_W = $clog2(max_int(half_bit_ticks, lead_ticks)) + 1;
`ifdef BMC_ENCODER_PARITY_EN
  localparam int FRAME_BITS = bit_considered + 1;
`else
  localparam int FRAME_BITS = bit_considered;
`endif
  localparam int BIT_W = $clog2(FRAME_BITS + 1);
  localparam logic [CNT_W-1:0] LEAD_LOAD = CNT_W'(lead_ticks - 1);
  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(half_bit_ticks - 1);

  logic [2:0]            state, state_nxt;
  logic [FRAME_BITS-1:0] shreg, frame_word;
  logic [BIT_W-1:0]      bit_cnt;
  logic                  xfer, tick_tc, tick_load;
  logic [CNT_W-1:0]      tick_val;

  assign xfer = tx.data_valid && tx.data_ready;

`ifdef BMC_ENCODER_PARITY_EN
  assign frame_word = {tx.data_in, ^tx.data_in};
`else
  assign frame_word = tx.data_in;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (xfer)    state_nxt = S_LEAD;
      S_LEAD:  if (tick_tc) state_nxt = S_SYNC;
      S_SYNC:  if (tick_tc) state_nxt = S_BIT_A;
      S_BIT_A: if (tick_tc) state_nxt = S_BIT_B;
      S_BIT_B: if (tick_tc) state_nxt = (bit_cnt == BIT_W'(1)) ? S_TAIL : S_BIT_A;
      S_TAIL:  if (tick_tc) state_nxt = S_IDLE;
      default:              state_nxt = S_IDLE;
    endcase
  end

  // Every transition is a state change, so the timer restarts exactly on each phase boundary.
  assign tick_load = (state_nxt != state);
  assign tick_val  = (state_nxt == S_IDLE) ? '0 :
                     (state_nxt == S_LEAD || state_nxt == S_TAIL) ? LEAD_LOAD : HALF_LOAD;

  bmc_tick_counter #(.W(CNT_W)) u_tick (
    .clk      (clk_96MHz),
    .rst_n    (reset_n),
    .load     (tick_load),
    .load_val (tick_val),
    .tc       (tick_tc)
  );

  always_ff @(posedge clk_96MHz or negedge reset_n) begin
    if (!reset_n) begin
      state                 <= S_IDLE;
      shreg                 <= '0;
      bit_cnt               <= '0;
      d_out                 <= 1'b0;
      e_out                 <= 1'b1;
      busy                  <= 1'b0;
      tx.data_ready         <= 1'b0;
      timestamp_frame_start <= '0;
    end else begin
      state         <= state_nxt;
      busy          <= (state_nxt != S_IDLE);
      // Qualified on the current state so ready rises one cycle after the envelope closes.
      tx.data_ready <= (state == S_IDLE) && enabled && !xfer;
      case (state)
        S_IDLE: if (xfer) begin
          shreg <= frame_word;
          e_out <= 1'b0;
        end
        S_LEAD: if (tick_tc) begin
          d_out                 <= ~d_out;
          timestamp_frame_start <= system_timestamp;
        end
        S_SYNC: if (tick_tc) begin
          d_out   <= ~d_out;
          bit_cnt <= BIT_W'(FRAME_BITS);
        end
        S_BIT_A: if (tick_tc && shreg[FRAME_BITS-1]) d_out <= ~d_out;
        S_BIT_B: if (tick_tc) begin
          d_out   <= ~d_out;
          shreg   <= shreg << 1;
          bit_cnt <= bit_cnt - BIT_W'(1);
        end
        S_TAIL: if (tick_tc) e_out <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bmc_encoder.sv
// tb/tb_bmc_encoder.sv - scoreboard bench for bmc_encoder with a sampled-line BMC reference decoder
module tb_bmc_encoder;
  import bmc_pkg::*;

`ifdef BMC_ENCODER_PARITY_EN
  localparam int NB = 18;
`else
  localparam int NB = 17;
`endif
  localparam int FRAME_LEN = 4 + 8 * (1 + 2 * NB) + 4;

  typedef struct {
    logic [17:0] word;
    int          len;
    logic [23:0] ts;
  } exp_t;

  logic        clk, reset_n, enabled;
  logic [23:0] ts;
  logic        d_out, e_out, busy;
  logic [23:0] tfs;

  bmc_encoder_if #(.W(17)) txif ();

  bmc_encoder dut (
    .clk_96MHz             (clk),
    .reset_n               (reset_n),
    .enabled               (enabled),
    .tx                    (txif),
    .system_timestamp      (ts),
    .d_out                 (d_out),
    .e_out                 (e_out),
    .busy                  (busy),
    .timestamp_frame_start (tfs)
  );

  int   total = 0, passed = 0;
  int   exp_frames = 0, falls = 0, gap = 0, last_gap = 0, overlap = 0, idx = 0;
  bit   in_frame = 0, abort_next = 0;
  exp_t sb[$];
  logic lv [0:1023];

  // Timestamp advances right after each falling edge, so it is stable across every rising edge.
  initial begin
    clk = 1'b0;
    ts  = '0;
    forever begin
      #5 clk = 1'b1;
      #5 clk = 1'b0;
      ts = ts + 24'd1;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time exceeded");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic finish_frame();
    exp_t        e;
    logic [17:0] w;
    int          edges;
    if (sb.size() == 0) begin
      chk("unexpected_frame", 32'(sb.size()), 1);
      return;
    end
    e = sb.pop_front();
    if (abort_next) begin
      abort_next = 0;
      return;
    end
    w     = '0;
    edges = 0;
    for (int k = 1; k < idx && k < 1024; k++) if (lv[k] !== lv[k-1]) edges++;
    for (int i = 0; i < NB; i++) w = {w[16:0], lv[20+16*i] !== lv[19+16*i]};
    chk("frame_data", 32'(w), 32'(e.word));
    chk("frame_len", 32'(idx), 32'(e.len));
    chk("frame_edges", 32'(edges), 32'(2 + NB + $countones(e.word)));
    chk("frame_ts", 32'(tfs), 32'(e.ts));
  endtask

  // Monitor: samples the line on falling edges and scores each completed envelope.
  initial begin
    forever begin
      @(negedge clk);
      if (txif.data_ready && busy) overlap++;
      if (!e_out) begin
        if (!in_frame) begin
          in_frame = 1;
          idx      = 0;
          falls++;
          last_gap = gap;
          gap      = 0;
        end
        if (idx < 1024) lv[idx] = d_out;
        idx++;
      end else begin
        if (in_frame) begin
          in_frame = 0;
          finish_frame();
        end
        gap++;
      end
    end
  end

  task automatic send(input logic [16:0] d, input bit keep);
    exp_t e;
    int   n = 0;
    txif.data_in    = d;
    txif.data_valid = 1'b1;
    while (!txif.data_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("send_accepted", 32'(n < 1000), 1);
    if (n >= 1000) begin
      txif.data_valid = 1'b0;
      return;
    end
`ifdef BMC_ENCODER_PARITY_EN
    e.word = {d, ^d};
`else
    e.word = {1'b0, d};
`endif
    e.len = FRAME_LEN;
    e.ts  = ts + 24'd4;
    sb.push_back(e);
    exp_frames++;
    @(negedge clk);
    if (!keep) txif.data_valid = 1'b0;
  endtask

  task automatic wait_done(input int max);
    int n = 0;
    while ((sb.size() != 0 || in_frame) && n < max) begin
      @(negedge clk);
      n++;
    end
    chk("drain_in_time", 32'(n < max), 1);
  endtask

  initial begin
    reset_n         = 1'b0;
    enabled         = 1'b1;
    txif.data_valid = 1'b0;
    txif.data_in    = '0;
    repeat (3) @(negedge clk);
    chk("rst_d_out", 32'(d_out), 0);
    chk("rst_e_out", 32'(e_out), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ready", 32'(txif.data_ready), 0);
    chk("rst_ts", 32'(tfs), 0);
    reset_n = 1'b1;
    @(negedge clk);

    send(17'h0B8D4, 0); wait_done(400);
    send(17'h1FFFF, 0); wait_done(400);
    send(17'h00000, 0); wait_done(400);

    send(17'h15555, 1);
    send(17'h0AAAA, 0);
    wait_done(800);
    chk("b2b_gap", 32'(last_gap), 2);

    send(17'h1ABCD, 0);
    repeat (156) @(negedge clk);
    abort_next = 1;
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_d_out", 32'(d_out), 0);
    chk("async_rst_e_out", 32'(e_out), 1);
    chk("async_rst_busy", 32'(busy), 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("abort_drained", 32'(sb.size()), 0);

    send(17'h12345, 0); wait_done(400);

    send(17'h1F0F0, 0);
    repeat (50) @(negedge clk);
    enabled         = 1'b0;
    txif.data_in    = 17'h00FFF;
    txif.data_valid = 1'b1;
    repeat (400) @(negedge clk);
    chk("no_frame_when_disabled", 32'(falls), 32'(exp_frames));
    chk("ready_low_disabled", 32'(txif.data_ready), 0);
    txif.data_valid = 1'b0;
    enabled         = 1'b1;
    wait_done(10);

    send(17'h00007, 0); wait_done(400);

    chk("ready_busy_overlap", 32'(overlap), 0);
    chk("frame_count", 32'(falls), 32'(exp_frames));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
